pwm_multi: RTL and testbench

PWM_MULTI -- requirements
Module: pwm_multi

---
 rtl/pwm_multi.sv | 103 ++++++++++
 tb/tb_pwm_multi.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
// Multi-channel PWM with shadowed duty registers and period-boundary reload.
// Define PWM_CENTER_ALIGN_EN to compile in the center-aligned (up/down) mode.
module pwm_multi #(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 4,
  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                center,
  input  logic [WIDTH-1:0]    period,
  input  logic                duty_wr,
  input  logic [CHW-1:0]      duty_ch,
  input  logic [WIDTH-1:0]    duty_data,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] pa;
  logic [WIDTH-1:0] shadow [CHANNELS];
  logic [WIDTH-1:0] active [CHANNELS];
  logic             bnd;
  logic             wr_ok;

  assign wr_ok = duty_wr && (32'(duty_ch) < CHANNELS);

`ifdef PWM_CENTER_ALIGN_EN
  logic dir_up;
  logic dir_nxt;
  logic mode_c;

  always_comb begin
    cnt_nxt = cnt + WIDTH'(1);
    dir_nxt = dir_up;
    if (mode_c) begin
      if (!dir_up) begin
        cnt_nxt = cnt - WIDTH'(1);
      end else if (cnt >= pa) begin
        // turn around at the top; Pa=0 just parks at zero
        cnt_nxt = (cnt == '0) ? '0 : cnt - WIDTH'(1);
        dir_nxt = 1'b0;
      end
    end else if (cnt >= pa) begin
      cnt_nxt = '0;
    end
    bnd = (cnt_nxt == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dir_up <= 1'b1;
      mode_c <= 1'b0;
    end else if (en) begin
      dir_up <= bnd ? 1'b1 : dir_nxt;
      if (bnd) mode_c <= center;
    end
  end
`else
  logic unused_center;
  assign unused_center = center;

  always_comb begin
    cnt_nxt = cnt + WIDTH'(1);
    if (cnt >= pa) cnt_nxt = '0;
    bnd = (cnt_nxt == '0);
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt          <= '0;
      pa           <= '0;
      pwm_out      <= '0;
      period_start <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (wr_ok) shadow[duty_ch] <= duty_data;
      if (!en) begin
        pwm_out      <= '0;
        period_start <= 1'b0;
      end else begin
        cnt          <= cnt_nxt;
        period_start <= bnd;
        for (int i = 0; i < CHANNELS; i++)
          pwm_out[i] <= (cnt < active[i]);
        if (bnd) begin
          pa <= period;
          // a write landing on the boundary bypasses the shadow
          for (int i = 0; i < CHANNELS; i++)
            active[i] <= (wr_ok && 32'(duty_ch) == i) ? duty_data
                                                     : shadow[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Randomized bench for pwm_multi against a period-position reference model.
// A second CHANNELS=3 instance exercises out-of-range channel writes.
module tb_pwm_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       center = 1'b0;
  logic [7:0] period = '0;
  logic       duty_wr = 1'b0;
  logic [1:0] duty_ch = '0;
  logic [7:0] duty_data = '0;
  logic [3:0] pwm_out;
  logic       period_start;
  logic [2:0] pwm3;
  logic       ps3;

  int checks = 0;
  int errors = 0;

  int   m_pos, m_pa;
  bit   m_c;
  int   m_sh [4];
  int   m_act [4];
  logic [3:0] exp_pwm;
  logic exp_ps;

  always #5 clk = ~clk;

  pwm_multi #(.WIDTH(8), .CHANNELS(4)) u_dut (
    .clk(clk), .rst(rst), .en(en), .center(center),
    .period(period), .duty_wr(duty_wr), .duty_ch(duty_ch),
    .duty_data(duty_data), .pwm_out(pwm_out),
    .period_start(period_start)
  );

  pwm_multi #(.WIDTH(8), .CHANNELS(3)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .center(center),
    .period(period), .duty_wr(duty_wr), .duty_ch(duty_ch),
    .duty_data(duty_data), .pwm_out(pwm3),
    .period_start(ps3)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int len_of();
    if (m_c) return (m_pa == 0) ? 1 : 2 * m_pa;
    return m_pa + 1;
  endfunction

  function automatic int cnt_of();
    if (!m_c) return m_pos;
    return (m_pos <= m_pa) ? m_pos : 2 * m_pa - m_pos;
  endfunction

  task automatic model_step();
    bit b;
    if (!rst) begin
      m_pos = 0; m_pa = 0; m_c = 0;
      exp_pwm = '0; exp_ps = 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_sh[i] = 0; m_act[i] = 0;
      end
      return;
    end
    if (duty_wr) m_sh[duty_ch] = int'(duty_data);
    if (!en) begin
      exp_pwm = '0; exp_ps = 1'b0;
      return;
    end
    for (int i = 0; i < 4; i++) exp_pwm[i] = (cnt_of() < m_act[i]);
    b = (m_pos + 1 >= len_of());
    exp_ps = b;
    if (b) begin
      m_pos = 0;
      m_pa = int'(period);
`ifdef PWM_CENTER_ALIGN_EN
      m_c = center;
`else
      m_c = 1'b0;
`endif
      for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
    end else begin
      m_pos++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("pwm", 32'(pwm_out), 32'(exp_pwm));
    chk("ps", 32'(period_start), 32'(exp_ps));
    chk("pwm3", 32'(pwm3), 32'(exp_pwm[2:0]));
    chk("ps3", 32'(ps3), 32'(exp_ps));
    duty_wr = 1'b0;
  endtask

  task automatic wr(input int ch, input int d);
    duty_wr = 1'b1;
    duty_ch = 2'(ch);
    duty_data = 8'(d);
    tick();
  endtask

  initial begin
    int hi [4];
    int nps;
    int dv [4];
    dv = '{0, 3, 10, 255};

    rst = 1'b0; en = 1'b1; duty_wr = 1'b1; duty_data = 8'h55;
    tick();
    tick();
    chk("rst_pwm", 32'(pwm_out), 0);
    chk("rst_ps", 32'(period_start), 0);

    rst = 1'b1; period = 8'd9; center = 1'b0;
    for (int i = 0; i < 4; i++) wr(i, dv[i]);
    repeat (25) tick();
    hi = '{0, 0, 0, 0};
    nps = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      for (int i = 0; i < 4; i++) hi[i] += int'(pwm_out[i]);
      nps += int'(period_start);
    end
    chk("ch0_hi", 32'(hi[0]), 0);
    chk("ch1_hi", 32'(hi[1]), 6);
    chk("ch2_hi", 32'(hi[2]), 20);
    chk("ch3_hi", 32'(hi[3]), 20);
    chk("ps_cnt", 32'(nps), 2);

    repeat (4) tick();
    wr(1, 7);
    repeat (25) tick();
    en = 1'b0;
    repeat (5) tick();
    chk("pause_pwm", 32'(pwm_out), 0);
    en = 1'b1;
    repeat (12) tick();

    period = 8'd0;
    repeat (12) tick();
    chk("p0_ps", 32'(period_start), 1);

`ifdef PWM_CENTER_ALIGN_EN
    center = 1'b1; period = 8'd4;
    wr(1, 2);
    repeat (30) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
`endif

    for (int k = 0; k < 4000; k++) begin
      rst = ($urandom_range(0, 299) != 0);
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) center = ~center;
      if ($urandom_range(0, 49) == 0)
        period = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                             : 8'($urandom_range(0, 12));
      duty_wr = ($urandom_range(0, 5) == 0);
      duty_ch = 2'($urandom);
      duty_data = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                              : 8'($urandom_range(0, 14));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
